// File: rtl/detector_pkg.sv
// Shared types and 7-segment character codes for the word detector.
package detector_pkg;

  typedef enum logic {
    SEARCH,
    CELEBRATE
  } state_t;

  localparam logic [7:0] H_SEG     = 8'h89;
  localparam logic [7:0] E_SEG     = 8'h86;
  localparam logic [7:0] L_SEG     = 8'hC7;
  localparam logic [7:0] O_SEG     = 8'hA3;
  localparam logic [7:0] CELEB_SEG = 8'h7F;
  localparam logic [7:0] BLANK_SEG = 8'hFF;

endpackage

// File: rtl/celeb_timer.sv
// Loadable down-counter; idles at zero once it has run out.
module celeb_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/fsm_pattern_detector.sv
// Programmable word detector on the keypad character stream; celebrates
// each completed match on the digit and keeps a saturating match count.
module fsm_pattern_detector
  import detector_pkg::*;
#(
  parameter int unsigned           CHAR_W       = 8,
  parameter int unsigned           MAX_LEN      = 8,
  parameter int unsigned           CELEB_CYCLES = 150000000,
  parameter int unsigned           CNT_W        = 8,
  parameter logic [CHAR_W-1:0]     CELEB_SEG    = detector_pkg::CELEB_SEG,
  parameter logic [CHAR_W-1:0]     BLANK_SEG    = detector_pkg::BLANK_SEG,
  localparam int unsigned          LEN_W        = $clog2(MAX_LEN + 1),
  localparam int unsigned          AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CHAR_W-1:0] cfg_data,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] char_in,
  output logic [CHAR_W-1:0] hex_out,
  output logic              celebrating,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic [LEN_W-1:0]  progress
);

  localparam int unsigned TMR_W = $clog2(CELEB_CYCLES + 1);

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    idx, idx_nxt;
  logic [LEN_W-1:0]    len;
  logic [CHAR_W-1:0]   pat [MAX_LEN];
  logic [CHAR_W-1:0]   hex_nxt;
  logic                pulse_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                tmr_load;
  logic                tmr_done;
  logic                cfg_any;
  logic                hit_cur;
  logic                hit_first;
  logic                at_last;

  celeb_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TMR_W'(CELEB_CYCLES - 1)),
    .done     (tmr_done)
  );

  assign cfg_any   = cfg_we | cfg_len_we;
  assign hit_cur   = (char_in == pat[idx[AW-1:0]]);
  assign hit_first = (char_in == pat[0]);
  assign at_last   = (idx == len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        pat[i] <= '0;
      end
    end else begin
      if (cfg_we && (32'(cfg_addr) < MAX_LEN)) begin
        pat[cfg_addr] <= cfg_data;
      end
      if (cfg_len_we) begin
        len <= (32'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      idx         <= '0;
      hex_out     <= BLANK_SEG;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      hex_out     <= hex_nxt;
      match_pulse <= pulse_nxt;
      match_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hex_nxt   = hex_out;
    pulse_nxt = 1'b0;
    cnt_nxt   = match_count;
    tmr_load  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (char_valid) begin
          hex_nxt = char_in;
          // A same-cycle config write takes priority: the char is shown only.
          if (!cfg_any && (len != '0)) begin
            if (hit_cur && at_last) begin
              state_nxt = CELEBRATE;
              idx_nxt   = '0;
              pulse_nxt = 1'b1;
              tmr_load  = 1'b1;
              hex_nxt   = CELEB_SEG;
              if (match_count != '1) begin
                cnt_nxt = match_count + 1'b1;
              end
            end else if (hit_cur) begin
              idx_nxt = idx + 1'b1;
            end else begin
              idx_nxt = hit_first ? LEN_W'(1) : '0;
            end
          end
        end
      end
      CELEBRATE: begin
        hex_nxt = CELEB_SEG;
        if (tmr_done) begin
          state_nxt = SEARCH;
          hex_nxt   = BLANK_SEG;
        end
      end
      default: state_nxt = SEARCH;
    endcase
    if (cfg_any) begin
      idx_nxt = '0;
    end
  end

  assign celebrating = (state == CELEBRATE);
  assign progress    = idx;

endmodule
